// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// baud divisor calculation common to the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Integer-truncated clocks per bit; both serializer and deserializer use it.
  function automatic int divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Push-side bus between the UART receive front end and the RX FIFO.
// Signal names are as seen from the deserializer (master).
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_full;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_push;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_overrun;

  modport master (
    input  i_full,
    output o_data,
    output o_push,
    output o_frame_err,
    output o_parity_err,
    output o_overrun
  );

  modport slave (
    output i_full,
    input  o_data,
    input  o_push,
    input  o_frame_err,
    input  o_parity_err,
    input  o_overrun
  );
endinterface

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins; the reset value is a
// parameter so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: mid-bit sampling of the synchronized RX line and a
// single-cycle push of each completed word plus its error flags into the RX FIFO.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PARITY_NONE
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   i_rx,
  output logic                   o_busy,
  uart_rx_deserializer_if.master fifo
);
  localparam int               DIVISOR   = divisor(CLK_FREQ, BAUD_RATE);
  localparam int               CNT_W     = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_TICK  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .d    (i_rx),
    .q    (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_flag_q, frame_flag_d;
  logic                 parity_flag_q, parity_flag_d;
  logic                 push_q, push_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 stop_fe;

  assign tick    = (cnt_q == CNT_TICK);
  // Frame error including the stop sample being taken this cycle.
  assign stop_fe = frame_err_q | ~rx_s;

  always_comb begin
    state_d       = state_q;
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_err_d   = frame_err_q;
    parity_err_d  = parity_err_q;
    data_d        = data_q;
    frame_flag_d  = frame_flag_q;
    parity_flag_d = parity_flag_q;
    push_d        = 1'b0;
    overrun_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_DATA;
            bit_cnt_d    = '0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          parity_err_d = ((^shift_q) ^ rx_s) != (PARITY == PARITY_ODD);
          state_d      = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          frame_err_d = stop_fe;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            // A full FIFO drops the word and leaves the visible outputs untouched.
            if (!fifo.i_full) begin
              push_d        = 1'b1;
              data_d        = shift_q;
              frame_flag_d  = stop_fe;
              parity_flag_d = parity_err_q;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = stop_fe ? ST_BREAK : ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      data_q        <= '0;
      frame_flag_q  <= 1'b0;
      parity_flag_q <= 1'b0;
      push_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      data_q        <= data_d;
      frame_flag_q  <= frame_flag_d;
      parity_flag_q <= parity_flag_d;
      push_q        <= push_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_busy            = (state_q != ST_IDLE);
  assign fifo.o_data       = data_q;
  assign fifo.o_push       = push_q;
  assign fifo.o_frame_err  = frame_flag_q;
  assign fifo.o_parity_err = parity_flag_q;
  assign fifo.o_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: an 8N1 receiver driven from a vector table plus hand-written
// corner sequences, and an 8E1 receiver for the parity cases.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int DIV      = 50000000 / 115200;
  localparam int HALF     = DIV / 2;
  localparam int LAT_8N1  = 2 + HALF + 9 * DIV + 1;
  localparam int LAT_8E1  = 2 + HALF + 10 * DIV + 1;
  localparam int GLITCH_T = 2 + HALF + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic rx_a, rx_b;
  logic busy_a, busy_b;

  uart_rx_deserializer_if #(.DATA_BITS(8)) fa ();
  uart_rx_deserializer_if #(.DATA_BITS(8)) fb ();

  uart_rx_deserializer u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .i_rx  (rx_a),
    .o_busy(busy_a),
    .fifo  (fa)
  );

  uart_rx_deserializer #(.PARITY(PARITY_EVEN)) u_dut_p (
    .clk   (clk),
    .n_rst (n_rst),
    .i_rx  (rx_b),
    .o_busy(busy_b),
    .fifo  (fb)
  );

  int cyc = 0;
  int push_a = 0, ovr_a = 0, push_b = 0, ovr_b = 0;
  int push_cyc_a = 0, push_cyc_b = 0;
  int fall_cyc = 0;
  logic [7:0] hist_a [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fa.o_push) begin
      push_a     <= push_a + 1;
      push_cyc_a <= cyc;
      if (push_a < 64) hist_a[push_a] <= fa.o_data;
    end
    if (fa.o_overrun) ovr_a <= ovr_a + 1;
    if (fb.o_push) begin
      push_b     <= push_b + 1;
      push_cyc_b <= cyc;
    end
    if (fb.o_overrun) ovr_b <= ovr_b + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends n line bits LSB first, one bit time each; sel=1 targets the parity DUT.
  task automatic send(input logic sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) fall_cyc = cyc;
      if (sel) rx_b = bits[i];
      else     rx_a = bits[i];
      wait_cyc(DIV);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       full;
    logic [7:0] exp_data;
    int         exp_push;
    int         exp_ovr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, o0, t;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1, 0};
    vecs[1] = '{8'hFF, 1'b0, 8'hFF, 1, 0};
    vecs[2] = '{8'h5A, 1'b1, 8'hFF, 0, 1};
    vecs[3] = '{8'h81, 1'b0, 8'h81, 1, 0};

    n_rst     = 1'b0;
    rx_a      = 1'b1;
    rx_b      = 1'b1;
    fa.i_full = 1'b0;
    fb.i_full = 1'b0;
    wait_cyc(5);
    check("reset o_data", int'(fa.o_data), 0);
    check("reset o_push", int'(fa.o_push), 0);
    check("reset o_frame_err", int'(fa.o_frame_err), 0);
    check("reset o_parity_err", int'(fa.o_parity_err), 0);
    check("reset o_overrun", int'(fa.o_overrun), 0);
    check("reset o_busy", int'(busy_a), 0);
    n_rst = 1'b1;
    wait_cyc(10);

    for (int v = 0; v < 4; v++) begin
      p0 = push_a;
      o0 = ovr_a;
      fa.i_full = vecs[v].full;
      send(1'b0, {6'b0, 1'b1, vecs[v].data, 1'b0}, 10);
      wait_cyc(4);
      fa.i_full = 1'b0;
      $display("vec %0d: sent 0x%02h full=%0b -> o_data 0x%02h", v, vecs[v].data, vecs[v].full, fa.o_data);
      check($sformatf("vec%0d push count", v), push_a - p0, vecs[v].exp_push);
      check($sformatf("vec%0d overrun count", v), ovr_a - o0, vecs[v].exp_ovr);
      check($sformatf("vec%0d o_data", v), int'(fa.o_data), int'(vecs[v].exp_data));
      check($sformatf("vec%0d o_frame_err", v), int'(fa.o_frame_err), 0);
      check($sformatf("vec%0d o_parity_err", v), int'(fa.o_parity_err), 0);
      if (vecs[v].exp_push == 1)
        check($sformatf("vec%0d push latency", v), push_cyc_a - fall_cyc, LAT_8N1);
    end

    // Short low glitch must be rejected at the start-bit centre.
    p0 = push_a;
    fall_cyc = cyc;
    rx_a = 1'b0;
    wait_cyc(50);
    check("glitch busy during", int'(busy_a), 1);
    wait_cyc(50);
    rx_a = 1'b1;
    for (int n = 0; n < 400 && busy_a; n++) @(negedge clk);
    t = cyc - fall_cyc;
    $display("glitch: busy dropped %0d cycles after fall", t);
    check("glitch busy drop time", t, GLITCH_T);
    wait_cyc(DIV);
    check("glitch push count", push_a - p0, 0);
    check("glitch busy after", int'(busy_a), 0);

    // Line held low: one frame with frame error, then BREAK until high.
    p0 = push_a;
    fall_cyc = cyc;
    rx_a = 1'b0;
    wait_cyc(20 * DIV);
    $display("break: held low 20 bit times, pushes=%0d", push_a - p0);
    check("break push count", push_a - p0, 1);
    check("break o_data", int'(fa.o_data), 0);
    check("break o_frame_err", int'(fa.o_frame_err), 1);
    check("break o_parity_err", int'(fa.o_parity_err), 0);
    check("break push latency", push_cyc_a - fall_cyc, LAT_8N1);
    check("break busy while low", int'(busy_a), 1);
    rx_a = 1'b1;
    wait_cyc(DIV);
    check("break push count after release", push_a - p0, 1);
    check("break busy after release", int'(busy_a), 0);

    // Even parity on the second receiver.
    p0 = push_b;
    send(1'b1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    wait_cyc(4);
    $display("parity: 0x03 with parity bit 1 -> parity_err %0b", fb.o_parity_err);
    check("par1 push count", push_b - p0, 1);
    check("par1 o_data", int'(fb.o_data), 8'h03);
    check("par1 o_parity_err", int'(fb.o_parity_err), 1);
    check("par1 o_frame_err", int'(fb.o_frame_err), 0);
    check("par1 push latency", push_cyc_b - fall_cyc, LAT_8E1);
    p0 = push_b;
    send(1'b1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    wait_cyc(4);
    $display("parity: 0x03 with parity bit 0 -> parity_err %0b", fb.o_parity_err);
    check("par0 push count", push_b - p0, 1);
    check("par0 o_parity_err", int'(fb.o_parity_err), 0);
    check("par0 overrun count", ovr_b, 0);

    // Reset in the middle of DATA discards the partial frame.
    p0 = push_a;
    o0 = ovr_a;
    send(1'b0, 16'b0000_0000_0000_0110, 4);
    wait_cyc(100);
    check("midframe busy before reset", int'(busy_a), 1);
    n_rst = 1'b0;
    rx_a  = 1'b1;
    wait_cyc(3);
    $display("reset mid-frame: o_data 0x%02h busy %0b", fa.o_data, busy_a);
    check("midreset o_data", int'(fa.o_data), 0);
    check("midreset o_push", int'(fa.o_push), 0);
    check("midreset o_frame_err", int'(fa.o_frame_err), 0);
    check("midreset o_busy", int'(busy_a), 0);
    check("midreset parity dut o_parity_err", int'(fb.o_parity_err), 0);
    n_rst = 1'b1;
    wait_cyc(10);
    check("midreset push count", push_a - p0, 0);
    check("midreset overrun count", ovr_a - o0, 0);
    p0 = push_a;
    send(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    wait_cyc(4);
    $display("after reset: sent 0x3C -> o_data 0x%02h", fa.o_data);
    check("post-reset push count", push_a - p0, 1);
    check("post-reset o_data", int'(fa.o_data), 8'h3C);
    check("post-reset o_frame_err", int'(fa.o_frame_err), 0);

    // Back-to-back frames with no idle gap.
    p0 = push_a;
    send(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    wait_cyc(4);
    $display("back-to-back: pushes=%0d", push_a - p0);
    check("b2b push count", push_a - p0, 2);
    if (p0 + 1 < 64) begin
      check("b2b first word", int'(hist_a[p0]), 8'h11);
      check("b2b second word", int'(hist_a[p0 + 1]), 8'h22);
    end
    check("b2b o_frame_err", int'(fa.o_frame_err), 0);
    check("b2b o_parity_err", int'(fa.o_parity_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
